// File: rtl/rvv_backend_vrf_read_server_pkg.sv
// Shared sizing constants and request/response bundle types for the
// dispatch-to-VRF read path.
package rvv_backend_vrf_read_server_pkg;

  localparam int VLEN                = 128;
  localparam int REGFILE_INDEX_WIDTH = 5;
  localparam int NUM_DP_VRF          = 6;
  localparam int NUM_VRF_WB          = 4;

  typedef struct packed {
    logic                           en;
    logic [REGFILE_INDEX_WIDTH-1:0] index;
  } VRF_RD_REQ_t;

  typedef struct packed {
    logic [NUM_DP_VRF-1:0]           en;
    logic [NUM_DP_VRF-1:0][VLEN-1:0] data;
  } VRF_RD_RSP_t;

endpackage

// File: rtl/rvv_backend_vrf_rsp_fifo.sv
// Two-entry response FIFO with registered occupancy; push is dropped when full,
// pop is ignored when empty.
module rvv_backend_vrf_rsp_fifo
  import rvv_backend_vrf_read_server_pkg::*;
#(
  parameter type entry_t = VRF_RD_RSP_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t data_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  entry_t     mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wptr_q, rptr_q;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Payload storage is left unreset; it is only observed while occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
    end
  end

endmodule

// File: rtl/rvv_backend_vrf_read_server.sv
// Vector register file with byte-strobed writeback and a write-first read
// bundle that is snapshotted into a two-entry response queue.
module rvv_backend_vrf_read_server
  import rvv_backend_vrf_read_server_pkg::*;
#(
  parameter int NUM_RD = NUM_DP_VRF,
  parameter int NUM_WR = NUM_VRF_WB,
  parameter int VLEN   = rvv_backend_vrf_read_server_pkg::VLEN,
  parameter int IDXW   = REGFILE_INDEX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_req_valid,
  output logic                         rd_req_ready,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*IDXW-1:0]       rd_index,
  output logic                         rd_rsp_valid,
  input  logic                         rd_rsp_ready,
  output logic [NUM_RD-1:0]            rd_rsp_en,
  output logic [NUM_RD*VLEN-1:0]       rd_data,
  input  logic [NUM_WR-1:0]            wr_valid,
  input  logic [NUM_WR*IDXW-1:0]       wr_index,
  input  logic [NUM_WR*VLEN-1:0]       wr_data,
  input  logic [NUM_WR*(VLEN/8)-1:0]   wr_strb
);

  localparam int NBYTES = VLEN / 8;
  localparam int NREGS  = 2 ** IDXW;

  typedef struct packed {
    logic [NUM_RD-1:0]           en;
    logic [NUM_RD-1:0][VLEN-1:0] data;
  } rsp_t;

  logic [VLEN-1:0] vrf_q [NREGS];
  rsp_t            push_entry, head_entry;
  logic            fifo_full, fifo_empty, push, pop;

  assign rd_req_ready = ~fifo_full;
  assign rd_rsp_valid = ~fifo_empty;
  assign push         = rd_req_valid & rd_req_ready;
  assign pop          = rd_rsp_valid & rd_rsp_ready;
  assign rd_rsp_en    = head_entry.en;
  assign rd_data      = head_entry.data;

  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        vrf_q[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_valid[w]) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (wr_strb[w*NBYTES+b]) begin
              vrf_q[wr_index[w*IDXW +: IDXW]][b*8 +: 8] <= wr_data[w*VLEN + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    push_entry = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      push_entry.en[i] = rd_en[i];
      if (rd_en[i]) begin
        push_entry.data[i] = vrf_q[rd_index[i*IDXW +: IDXW]];
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_valid[w] && (wr_index[w*IDXW +: IDXW] == rd_index[i*IDXW +: IDXW])) begin
            for (int b = 0; b < NBYTES; b++) begin
              if (wr_strb[w*NBYTES+b]) begin
                push_entry.data[i][b*8 +: 8] = wr_data[w*VLEN + b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  rvv_backend_vrf_rsp_fifo #(
    .entry_t (rsp_t)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_rvv_backend_vrf_read_server.sv
// Directed self-checking bench for the VRF read server: write/read latency,
// bypass, write conflicts, backpressure with snapshots, disabled lanes, reset.
module tb_rvv_backend_vrf_read_server;

  localparam int NRD = 6;
  localparam int NWR = 4;
  localparam int VL  = 128;
  localparam int IW  = 5;
  localparam int NB  = VL / 8;

  logic               clk;
  logic               rst;
  logic               rd_req_valid;
  logic               rd_req_ready;
  logic [NRD-1:0]     rd_en;
  logic [NRD*IW-1:0]  rd_index;
  logic               rd_rsp_valid;
  logic               rd_rsp_ready;
  logic [NRD-1:0]     rd_rsp_en;
  logic [NRD*VL-1:0]  rd_data;
  logic [NWR-1:0]     wr_valid;
  logic [NWR*IW-1:0]  wr_index;
  logic [NWR*VL-1:0]  wr_data;
  logic [NWR*NB-1:0]  wr_strb;

  int tests  = 0;
  int failed = 0;

  rvv_backend_vrf_read_server dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_en        (rd_en),
    .rd_index     (rd_index),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_en    (rd_rsp_en),
    .rd_data      (rd_data),
    .wr_valid     (wr_valid),
    .wr_index     (wr_index),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    rd_req_valid = 1'b0;
    rd_en        = '0;
    rd_index     = '0;
    wr_valid     = '0;
    wr_index     = '0;
    wr_data      = '0;
    wr_strb      = '0;
  endtask

  task automatic setWrite(input int w, input logic [IW-1:0] idx,
                          input logic [VL-1:0] data, input logic [NB-1:0] strb);
    wr_valid[w]            = 1'b1;
    wr_index[w*IW +: IW]   = idx;
    wr_data[w*VL +: VL]    = data;
    wr_strb[w*NB +: NB]    = strb;
  endtask

  task automatic setRead(input int p, input logic [IW-1:0] idx);
    rd_req_valid         = 1'b1;
    rd_en[p]             = 1'b1;
    rd_index[p*IW +: IW] = idx;
  endtask

  task automatic checkOutput(input string tag, input logic [VL-1:0] obs, input logic [VL-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [VL-1:0] d11, d33, d44, d55, dAA, d01;
    d11 = {NB{8'h11}};
    d33 = {NB{8'h33}};
    d44 = {NB{8'h44}};
    d55 = {NB{8'h55}};
    dAA = {NB{8'hAA}};
    d01 = {NB{8'h01}};

    rst          = 1'b1;
    rd_rsp_ready = 1'b1;
    clearInputs();
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset_rsp_valid", VL'(rd_rsp_valid), VL'(1'b0));
    checkOutput("reset_req_ready", VL'(rd_req_ready), VL'(1'b1));

    // Write v3 then read it through the array on the next cycle.
    setWrite(0, 5'd3, d11, '1);
    applyStimulus();
    clearInputs();
    setRead(0, 5'd3);
    applyStimulus();
    clearInputs();
    checkOutput("wr_rd_valid", VL'(rd_rsp_valid), VL'(1'b1));
    checkOutput("wr_rd_data0", rd_data[0*VL +: VL], d11);
    checkOutput("wr_rd_en", VL'(rd_rsp_en), VL'(6'b000001));
    applyStimulus();
    checkOutput("drain_valid", VL'(rd_rsp_valid), VL'(1'b0));

    // Same-cycle bypass of a partial-strobe write.
    setWrite(1, 5'd5, dAA, 16'h00FF);
    setRead(2, 5'd5);
    applyStimulus();
    clearInputs();
    checkOutput("bypass_data2", rd_data[2*VL +: VL], {64'h0, {8{8'hAA}}});
    applyStimulus();

    // Write conflict: ports 0 and 3 target v7, port 3 must win.
    setWrite(0, 5'd7, d01, '1);
    setWrite(3, 5'd7, d33, '1);
    applyStimulus();
    clearInputs();
    setRead(5, 5'd7);
    applyStimulus();
    clearInputs();
    checkOutput("conflict_data5", rd_data[5*VL +: VL], d33);
    applyStimulus();

    // Backpressure: three bundles against a stalled consumer.
    rd_rsp_ready = 1'b0;
    setRead(0, 5'd3);
    applyStimulus();
    checkOutput("bp_ready_after1", VL'(rd_req_ready), VL'(1'b1));
    clearInputs();
    setRead(0, 5'd7);
    setWrite(0, 5'd3, d44, '1);
    applyStimulus();
    checkOutput("bp_ready_after2", VL'(rd_req_ready), VL'(1'b0));
    checkOutput("bp_head_A", rd_data[0*VL +: VL], d11);
    clearInputs();
    setRead(0, 5'd3);
    setWrite(0, 5'd7, d55, '1);
    applyStimulus();
    wr_valid = '0;
    checkOutput("bp_full_ready", VL'(rd_req_ready), VL'(1'b0));
    checkOutput("bp_head_A_hold", rd_data[0*VL +: VL], d11);
    rd_rsp_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_ready_after_pop", VL'(rd_req_ready), VL'(1'b1));
    checkOutput("bp_head_B", rd_data[0*VL +: VL], d33);
    rd_rsp_ready = 1'b0;
    applyStimulus();
    checkOutput("bp_C_accepted", VL'(rd_req_ready), VL'(1'b0));
    checkOutput("bp_head_B_hold", rd_data[0*VL +: VL], d33);
    clearInputs();
    rd_rsp_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_head_C", rd_data[0*VL +: VL], d44);
    applyStimulus();
    checkOutput("bp_drained", VL'(rd_rsp_valid), VL'(1'b0));

    // Disabled lanes are zero and the enable mask is echoed.
    for (int p = 0; p < NRD; p++) rd_index[p*IW +: IW] = 5'd3;
    rd_req_valid = 1'b1;
    rd_en        = 6'b100001;
    applyStimulus();
    clearInputs();
    checkOutput("dis_en", VL'(rd_rsp_en), VL'(6'b100001));
    checkOutput("dis_lane0", rd_data[0*VL +: VL], d44);
    checkOutput("dis_lane1", rd_data[1*VL +: VL], '0);
    checkOutput("dis_lane4", rd_data[4*VL +: VL], '0);
    checkOutput("dis_lane5", rd_data[5*VL +: VL], d44);
    applyStimulus();

    // Reset with two queued entries discards them and clears the array.
    rd_rsp_ready = 1'b0;
    setRead(0, 5'd7);
    applyStimulus();
    applyStimulus();
    clearInputs();
    checkOutput("rst_pre_full", VL'(rd_req_ready), VL'(1'b0));
    rst = 1'b1;
    setWrite(2, 5'd9, d55, '1);
    applyStimulus();
    rst = 1'b0;
    clearInputs();
    checkOutput("rst_rsp_valid", VL'(rd_rsp_valid), VL'(1'b0));
    checkOutput("rst_req_ready", VL'(rd_req_ready), VL'(1'b1));
    rd_rsp_ready = 1'b1;
    setRead(0, 5'd7);
    setRead(1, 5'd9);
    applyStimulus();
    clearInputs();
    checkOutput("rst_read_valid", VL'(rd_rsp_valid), VL'(1'b1));
    checkOutput("rst_array_v7", rd_data[0*VL +: VL], '0);
    checkOutput("rst_array_v9", rd_data[1*VL +: VL], '0);
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
